// File: rtl/uart_mem_pkg.sv
// Shared types and constants for the UART memory command sequencer.
//   state_t : command FSM state encoding
//   CMD_*   : host command opcodes, RSP_* : one-byte response codes
//   is_cmd  : true for a recognised command opcode
package uart_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_ADDR,
      ST_GET_DATA,
      ST_MEM_WR,
      ST_MEM_RD,
      ST_WAIT_RD,
      ST_SEND
   } state_t;

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] RSP_ACK = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h3F;

   function automatic logic is_cmd(input logic [7:0] b);
      return (b == CMD_WR) || (b == CMD_RD);
   endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte timeout counter on the baud-tick timebase.
//   clk, rst : clock, async active-high reset
//   clr      : hold the count at zero (outside the byte-wait states, or on a new byte)
//   en       : advance one count (baud_tick while waiting for a byte)
//   expire   : pulse on the tick that brings the count to TIMEOUT_BAUD
module uart_idle_timer #(
   parameter int unsigned TIMEOUT_BAUD = 160
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int unsigned W = $clog2(TIMEOUT_BAUD + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_BAUD - 1);

   logic [W-1:0] count;

   // clr masks expiry so a byte arriving on the expiring tick wins.
   assign expire = en && !clr && (count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !expire) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/uart_mem_cmd_ctrl.sv
// Host command sequencer between the UART RX/TX bytes and the memory port.
//   clk, rst            : clock, async active-high reset
//   baud_tick           : bit-period pulse, timeout timebase
//   rx_byte/valid/err   : received byte stream and framing error pulse
//   tx_byte/valid/ready : one-byte response, held until accepted
//   mem_*               : address/data, one-cycle write/read strobes, read return
//   busy, cmd_done      : not-idle flag, pulse after the response handshake
//   err_count           : saturating count of protocol/framing/timeout errors
//
// state       | meaning
// ------------+-------------------------------------------------
// ST_IDLE     | waiting for an opcode byte
// ST_GET_ADDR | waiting for the address byte (timed)
// ST_GET_DATA | waiting for the write data byte (timed)
// ST_MEM_WR   | mem_we asserted this cycle, queue 'K'
// ST_MEM_RD   | mem_re asserted this cycle
// ST_WAIT_RD  | waiting for mem_rvalid, no timeout
// ST_SEND     | tx_valid held until tx_ready
module uart_mem_cmd_ctrl
   import uart_mem_pkg::*;
#(
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned TIMEOUT_BAUD = 160
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              baud_tick,
   input  logic [7:0]        rx_byte,
   input  logic              rx_valid,
   input  logic              rx_err,
   output logic [7:0]        tx_byte,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_rvalid,
   output logic              busy,
   output logic              cmd_done,
   output logic [7:0]        err_count
);
   state_t state;
   logic   op_wr;
   logic   in_get;
   logic   expire;
   logic   err_evt;

   assign in_get = (state == ST_GET_ADDR) || (state == ST_GET_DATA);

   uart_idle_timer #(.TIMEOUT_BAUD(TIMEOUT_BAUD)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (!in_get || rx_valid),
      .en     (in_get && baud_tick),
      .expire (expire)
   );

   // One flag per cycle so coincident error sources count once.
   always_comb begin
      err_evt = 1'b0;
      case (state)
         ST_IDLE:                  err_evt = rx_err || (rx_valid && !is_cmd(rx_byte));
         ST_GET_ADDR, ST_GET_DATA: err_evt = rx_err || expire;
         default:                  err_evt = rx_valid;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_wr     <= 1'b0;
         tx_byte   <= 8'h00;
         tx_valid  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'h00;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         busy      <= 1'b0;
         cmd_done  <= 1'b0;
         err_count <= 8'h00;
      end else begin
         mem_we   <= 1'b0;
         mem_re   <= 1'b0;
         cmd_done <= 1'b0;
         if (err_evt && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
         case (state)
            ST_IDLE: begin
               // A framing error on the opcode frame discards the byte.
               if (rx_valid && !rx_err) begin
                  busy <= 1'b1;
                  if (is_cmd(rx_byte)) begin
                     op_wr <= (rx_byte == CMD_WR);
                     state <= ST_GET_ADDR;
                  end else begin
                     tx_byte  <= RSP_ERR;
                     tx_valid <= 1'b1;
                     state    <= ST_SEND;
                  end
               end
            end
            ST_GET_ADDR: begin
               if (rx_err || (expire && !rx_valid)) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (rx_valid) begin
                  mem_addr <= ADDR_W'(rx_byte);
                  if (op_wr) begin
                     state <= ST_GET_DATA;
                  end else begin
                     mem_re <= 1'b1;
                     state  <= ST_MEM_RD;
                  end
               end
            end
            ST_GET_DATA: begin
               if (rx_err || (expire && !rx_valid)) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (rx_valid) begin
                  mem_wdata <= rx_byte;
                  mem_we    <= 1'b1;
                  state     <= ST_MEM_WR;
               end
            end
            ST_MEM_WR: begin
               tx_byte  <= RSP_ACK;
               tx_valid <= 1'b1;
               state    <= ST_SEND;
            end
            ST_MEM_RD: begin
               state <= ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
               if (mem_rvalid) begin
                  tx_byte  <= mem_rdata;
                  tx_valid <= 1'b1;
                  state    <= ST_SEND;
               end
            end
            ST_SEND: begin
               // cmd_done is registered, so it appears with busy falling.
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  cmd_done <= 1'b1;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mem_cmd_ctrl.sv
module tb_uart_mem_cmd_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       baud_tick = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_err = 1'b0;
   logic [7:0] tx_byte;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic       mem_re;
   logic [7:0] mem_rdata = 8'h00;
   logic       mem_rvalid = 1'b0;
   logic       busy;
   logic       cmd_done;
   logic [7:0] err_count;

   int n_vec  = 0;
   int n_miss = 0;
   int exp_err;

   uart_mem_cmd_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .baud_tick  (baud_tick),
      .rx_byte    (rx_byte),
      .rx_valid   (rx_valid),
      .rx_err     (rx_err),
      .tx_byte    (tx_byte),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .busy       (busy),
      .cmd_done   (cmd_done),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rv;
      logic [7:0] rb;
      logic       re;
      logic       rdv;
      logic [7:0] rd;
      logic       rdy;
      logic [36:0] exp;   // {tx, txv, addr, wdata, we, re, busy, done, err}
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string nm, logic rv, logic [7:0] rb, logic re,
                               logic rdv, logic [7:0] rd, logic rdy,
                               logic [7:0] tx, logic txv, logic [7:0] ad,
                               logic [7:0] wd, logic we, logic mre, logic bz,
                               logic dn, logic [7:0] er);
      vec_t v;
      v.name = nm; v.rv = rv; v.rb = rb; v.re = re;
      v.rdv = rdv; v.rd = rd; v.rdy = rdy;
      v.exp = {tx, txv, ad, wd, we, mre, bz, dn, er};
      return v;
   endfunction

   function automatic logic [36:0] outs();
      return {tx_byte, tx_valid, mem_addr, mem_wdata, mem_we, mem_re, busy, cmd_done, err_count};
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %h required %h", nm, got, want);
      end
   endtask

   // Drive one cycle of inputs, then sample #1 after the capturing edge.
   task automatic step(input logic rv, input logic [7:0] rb, input logic re,
                       input logic bt, input logic rdv, input logic [7:0] rd,
                       input logic rdy);
      rx_valid = rv; rx_byte = rb; rx_err = re; baud_tick = bt;
      mem_rvalid = rdv; mem_rdata = rd; tx_ready = rdy;
      @(posedge clk);
      #1;
      rx_valid = 1'b0; rx_err = 1'b0; baud_tick = 1'b0;
      mem_rvalid = 1'b0; tx_ready = 1'b0;
   endtask

   task automatic idle_cycle();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      step(1'b1, b, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      logic ok;

      //          name            rv rb     re rdv rd     rdy  tx     txv addr   wd     we re bz dn err
      vecs.push_back(mk("idle",        0, 8'h00, 0, 0, 8'h00, 0,  8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'd0));
      vecs.push_back(mk("wr_cmd",      1, 8'h57, 0, 0, 8'h00, 0,  8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'd0));
      vecs.push_back(mk("wr_addr",     1, 8'h10, 0, 0, 8'h00, 0,  8'h00, 0, 8'h10, 8'h00, 0, 0, 1, 0, 8'd0));
      vecs.push_back(mk("wr_data",     1, 8'hA5, 0, 0, 8'h00, 0,  8'h00, 0, 8'h10, 8'hA5, 1, 0, 1, 0, 8'd0));
      vecs.push_back(mk("wr_rsp",      0, 8'h00, 0, 0, 8'h00, 0,  8'h4B, 1, 8'h10, 8'hA5, 0, 0, 1, 0, 8'd0));
      vecs.push_back(mk("wr_hs",       0, 8'h00, 0, 0, 8'h00, 1,  8'h4B, 0, 8'h10, 8'hA5, 0, 0, 0, 1, 8'd0));
      vecs.push_back(mk("wr_after",    0, 8'h00, 0, 0, 8'h00, 0,  8'h4B, 0, 8'h10, 8'hA5, 0, 0, 0, 0, 8'd0));
      vecs.push_back(mk("rd_cmd",      1, 8'h52, 0, 0, 8'h00, 0,  8'h4B, 0, 8'h10, 8'hA5, 0, 0, 1, 0, 8'd0));
      vecs.push_back(mk("rd_addr",     1, 8'h10, 0, 0, 8'h00, 0,  8'h4B, 0, 8'h10, 8'hA5, 0, 1, 1, 0, 8'd0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk("rd_wait",  0, 8'h00, 0, 0, 8'h00, 0,  8'h4B, 0, 8'h10, 8'hA5, 0, 0, 1, 0, 8'd0));
      vecs.push_back(mk("rd_rvalid",   0, 8'h00, 0, 1, 8'h3C, 0,  8'h3C, 1, 8'h10, 8'hA5, 0, 0, 1, 0, 8'd0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk("rd_hold",  0, 8'h00, 0, 0, 8'h00, 0,  8'h3C, 1, 8'h10, 8'hA5, 0, 0, 1, 0, 8'd0));
      vecs.push_back(mk("rd_hs",       0, 8'h00, 0, 0, 8'h00, 1,  8'h3C, 0, 8'h10, 8'hA5, 0, 0, 0, 1, 8'd0));
      vecs.push_back(mk("rd_after",    0, 8'h00, 0, 0, 8'h00, 0,  8'h3C, 0, 8'h10, 8'hA5, 0, 0, 0, 0, 8'd0));
      vecs.push_back(mk("unk_byte",    1, 8'h41, 0, 0, 8'h00, 0,  8'h3F, 1, 8'h10, 8'hA5, 0, 0, 1, 0, 8'd1));
      vecs.push_back(mk("unk_hs",      0, 8'h00, 0, 0, 8'h00, 1,  8'h3F, 0, 8'h10, 8'hA5, 0, 0, 0, 1, 8'd1));
      vecs.push_back(mk("unk_byte2",   1, 8'h41, 0, 0, 8'h00, 0,  8'h3F, 1, 8'h10, 8'hA5, 0, 0, 1, 0, 8'd2));
      vecs.push_back(mk("drop_send",   1, 8'h55, 0, 0, 8'h00, 0,  8'h3F, 1, 8'h10, 8'hA5, 0, 0, 1, 0, 8'd3));
      vecs.push_back(mk("drop_hs",     0, 8'h00, 0, 0, 8'h00, 1,  8'h3F, 0, 8'h10, 8'hA5, 0, 0, 0, 1, 8'd3));
      vecs.push_back(mk("abort_cmd",   1, 8'h52, 0, 0, 8'h00, 0,  8'h3F, 0, 8'h10, 8'hA5, 0, 0, 1, 0, 8'd3));
      vecs.push_back(mk("abort_err",   0, 8'h00, 1, 0, 8'h00, 0,  8'h3F, 0, 8'h10, 8'hA5, 0, 0, 0, 0, 8'd4));
      vecs.push_back(mk("idle_err_rv", 1, 8'h52, 1, 0, 8'h00, 0,  8'h3F, 0, 8'h10, 8'hA5, 0, 0, 0, 0, 8'd5));
      vecs.push_back(mk("abort_cmd2",  1, 8'h52, 0, 0, 8'h00, 0,  8'h3F, 0, 8'h10, 8'hA5, 0, 0, 1, 0, 8'd5));
      vecs.push_back(mk("err_beats_rv",1, 8'h77, 1, 0, 8'h00, 0,  8'h3F, 0, 8'h10, 8'hA5, 0, 0, 0, 0, 8'd6));

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_state", 64'(outs()), 64'd0);

      foreach (vecs[i]) begin
         step(vecs[i].rv, vecs[i].rb, vecs[i].re, 1'b0, vecs[i].rdv, vecs[i].rd, vecs[i].rdy);
         chk(vecs[i].name, 64'(outs()), 64'(vecs[i].exp));
      end
      exp_err = 6;

      // Timeout in GET_DATA: 159 ticks hold, the 160th aborts silently.
      send_byte(8'h57);
      send_byte(8'h20);
      chk("to_addr", 64'({busy, mem_addr}), 64'({1'b1, 8'h20}));
      ok = 1'b1;
      for (int i = 0; i < 159; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
         if (!busy || mem_we || tx_valid) ok = 1'b0;
      end
      chk("to_hold", 64'(ok), 64'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      exp_err++;
      chk("to_expire", 64'({busy, tx_valid, mem_we, err_count}), 64'({3'b000, 8'(exp_err)}));

      // Read parses normally after the timeout.
      send_byte(8'h52);
      send_byte(8'h20);
      chk("to_rd_re", 64'({mem_re, mem_addr}), 64'({1'b1, 8'h20}));
      idle_cycle();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
      chk("to_rd_tx", 64'({tx_valid, tx_byte}), 64'({1'b1, 8'h99}));
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("to_rd_hs", 64'({cmd_done, busy, tx_valid}), 64'(3'b100));

      // Byte arriving on the expiring tick wins.
      send_byte(8'h57);
      send_byte(8'h30);
      repeat (159) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("tie_we", 64'({mem_we, mem_wdata, busy, err_count}), 64'({1'b1, 8'h5A, 1'b1, 8'(exp_err)}));
      idle_cycle();
      chk("tie_rsp", 64'({tx_valid, tx_byte}), 64'({1'b1, 8'h4B}));
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("tie_hs", 64'(cmd_done), 64'd1);

      // Error saturation via framing errors in IDLE.
      for (int i = 0; i < 100; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      exp_err += 100;
      chk("err_mid", 64'(err_count), 64'(exp_err));
      for (int i = 0; i < 200; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("err_sat", 64'(err_count), 64'd255);
      send_byte(8'h41);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("err_sat_hold", 64'({err_count, cmd_done}), 64'({8'd255, 1'b1}));

      // Reset while waiting for read data: nothing leaks out afterwards.
      send_byte(8'h52);
      send_byte(8'h44);
      idle_cycle();
      chk("pre_rst_wait", 64'({busy, mem_addr}), 64'({1'b1, 8'h44}));
      rst = 1'b1;
      #1;
      chk("rst_wait_rd", 64'(outs()), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
      idle_cycle();
      chk("rst_wait_after", 64'(outs()), 64'd0);

      // Reset while holding a response.
      send_byte(8'h00);
      chk("pre_rst_send", 64'({tx_valid, tx_byte, err_count}), 64'({1'b1, 8'h3F, 8'd1}));
      rst = 1'b1;
      #1;
      chk("rst_send", 64'(outs()), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("rst_send_after", 64'(outs()), 64'd0);

      // Full write still works after reset.
      send_byte(8'h57);
      send_byte(8'h01);
      send_byte(8'h02);
      chk("post_rst_wr", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, 8'h01, 8'h02}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/uart_mem_cmd_ctrl.md
# uart_mem_cmd_ctrl

Command sequencer between the UART receiver/transmitter and the on-chip register/memory port of the memory-access subsystem. It parses byte-level host commands from the RX stream, issues single-cycle memory read/write strobes, and sequences the one-byte response onto the TX path. It also guards against stalled or corrupt frames with a baud-tick inter-byte timeout and a saturating error counter.

## Interface
- ADDR_W, 8, memory address width; command address byte zero-extended to ADDR_W
- TIMEOUT_BAUD, 160, inter-byte timeout in baud_tick periods (~16 byte times at 115200)
- clk  in  1  system clock
- rst  in  1  reset rst, asynchronous, active-high
- baud_tick  in  1  one-clk pulse per bit period (115200), timeout timebase
- rx_byte  in  8  received byte, valid only with rx_valid
- rx_valid  in  1  one-clk pulse, new byte
- rx_err  in  1  one-clk pulse, framing error on current frame
- tx_byte  out  8  response byte
- tx_valid  out  1  response available; held until tx_ready
- tx_ready  in  1  transmitter accepts tx_byte when tx_valid&&tx_ready
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  8  write data
- mem_we  out  1  one-clk write strobe
- mem_re  out  1  one-clk read strobe
- mem_rdata  in  8  read data, valid with mem_rvalid
- mem_rvalid  in  1  one-clk pulse, read data returned (earliest cycle after mem_re)
- busy  out  1  high whenever state != IDLE
- cmd_done  out  1  one-clk pulse on the response handshake cycle
- err_count  out  8  saturating error count (saturates at 255)

## Operation
- Protocol: write = 0x57 'W', addr, data -> response 0x4B 'K'; read = 0x52 'R', addr -> response mem_rdata; any other first byte -> response 0x3F '?' and err_count+1.
- States: IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, WAIT_RD, SEND.
- IDLE: rx_valid with 'W' or 'R' -> GET_ADDR (latches op); other byte -> SEND with '?'.
- GET_ADDR: rx_valid -> latch mem_addr; write op -> GET_DATA, read op -> MEM_RD.
- GET_DATA: rx_valid -> latch mem_wdata, -> MEM_WR.
- MEM_WR: mem_we=1 for one cycle, -> SEND with 'K'. MEM_RD: mem_re=1 for one cycle, -> WAIT_RD.
- WAIT_RD: mem_rvalid -> latch mem_rdata into tx_byte, -> SEND. No timeout; only rst exits.
- SEND: tx_valid=1, tx_byte stable; on tx_valid&&tx_ready: cmd_done=1, -> IDLE.
- Timeout: counter clears on entry to GET_ADDR/GET_DATA and on every rx_valid; increments on baud_tick there; reaching TIMEOUT_BAUD -> IDLE, err_count+1, no response.
- rx_err in GET_ADDR/GET_DATA: abort -> IDLE, err_count+1, no response. rx_err in IDLE: err_count+1, stay IDLE.
- rx_valid in MEM_WR/MEM_RD/WAIT_RD/SEND: byte dropped, err_count+1.
- Simultaneous rx_valid and timeout expiry: byte wins, timer clears. Simultaneous rx_valid and rx_err: rx_err wins (abort).
- Multiple error events in one cycle count once.

## Timing
- Reset values: state IDLE, tx_byte 0, tx_valid 0, mem_addr 0, mem_wdata 0, mem_we 0, mem_re 0, busy 0, cmd_done 0, err_count 0, timer 0.
- All outputs registered.
- Write: data byte rx_valid at cycle N -> mem_we at N+1 -> tx_valid at N+2.
- Read: addr byte rx_valid at N -> mem_re at N+1; mem_rvalid at M -> tx_valid at M+1.
- Unknown command byte at N -> tx_valid '?' at N+1.
- Handshake at cycle H -> busy low at H+1; new command byte accepted from H+1.
- mem_addr and mem_wdata are held stable from latch until the next command latches new values.
- rst mid-command: immediate return to reset values; pending strobes and response discarded.

## Structure
- Package uart_mem_pkg: state enum; CMD_WR=8'h57, CMD_RD=8'h52, RSP_ACK=8'h4B, RSP_ERR=8'h3F.
- Sub-module uart_idle_timer: baud-tick timeout counter with clear/enable/expire ports, width $clog2(TIMEOUT_BAUD+1).

## Test plan
- 'W',0x10,0xA5 -> one mem_we, addr 0x10, wdata 0xA5; tx 0x4B; cmd_done one pulse.
- 'R',0x10, mem_rdata 0x3C returned 3 cycles after mem_re -> tx_byte 0x3C, tx_valid held 5 cycles with tx_ready low, then single handshake.
- 0x41 -> tx 0x3F, err_count 1, no mem strobe.
- 'W',0x20, then 160 baud_ticks idle -> IDLE, err_count+1, no mem_we, no tx; next 'R' parses normally.
- 'R' then rx_err -> abort, err_count+1; extra rx_valid during SEND -> dropped, err_count+1; 300 errors -> err_count 255.
- Assert rst in WAIT_RD and again in SEND -> all outputs at reset values next cycle; no late mem_we or tx_valid.
